// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detectors.
package seq_det_pkg;

  localparam int          DEF_PAT_W = 5;
  localparam logic [31:0] DEF_PAT   = 32'b10110;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  localparam bit OVERLAP_OFF = 1'b0;
  localparam bit OVERLAP_ON  = 1'b1;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter with synchronous clear and sticky full flag.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_w
    $error("seq_det_sat_cnt: CNT_W out of range");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
      sat_d = (cnt_d == '1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with match counter.
// Optional don't-care mask: define SEQ_DET_MASK_EN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT),
  parameter bit               OVERLAP = OVERLAP_ON,
  parameter int               CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_i,
  input  logic             in_valid_i,
  input  logic             pat_load_i,
  input  logic [PAT_W-1:0] pat_in_i,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in_i,
`endif
  input  logic             cnt_clr_i,
  output logic             out_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             cnt_sat_o
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_w
    $error("seq_det_prog: PAT_W out of range");
  end

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             out_q;

  logic [PAT_W-1:0] shifted;
  logic [FW-1:0]    fill_inc;
  logic             eq;
  logic             hit;

  assign shifted  = {hist_q[PAT_W-2:0], in_i};
  assign fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_q, mask_d;

  assign eq = (((shifted ^ pat_q) & ~mask_q) == '0);

  always_comb begin
    mask_d = mask_q;
    if (pat_load_i) mask_d = pat_mask_in_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mask_q <= '0;
    else         mask_q <= mask_d;
  end
`else
  assign eq = (shifted == pat_q);
`endif

  // Load beats sampling; a stalled or loading edge never flags a match.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    hit    = 1'b0;
    if (pat_load_i) begin
      pat_d  = pat_in_i;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid_i) begin
      hist_d = shifted;
      fill_d = fill_inc;
      hit    = (fill_inc == FULL) && eq;
      if (hit && (OVERLAP == OVERLAP_OFF)) fill_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_RST;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= hit;
    end
  end

  assign out_o = out_q;

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (hit),
    .clr_i  (cnt_clr_i),
    .cnt_o  (match_cnt_o),
    .sat_o  (cnt_sat_o)
  );

endmodule

// File: tb/tb_seq_det_prog.sv
// Randomised bench for seq_det_prog: overlap, non-overlap and 2-bit counter
// instances share one stimulus stream and a queue-based reference model.
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_b, vld, ld, clr;
  logic [4:0] pin;

  logic       o0, o1, o2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic       s0, s1, s2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_det_prog #(.OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_b), .in_valid_i(vld),
    .pat_load_i(ld), .pat_in_i(pin),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in_i(5'b0),
`endif
    .cnt_clr_i(clr), .out_o(o0), .match_cnt_o(c0), .cnt_sat_o(s0));

  seq_det_prog #(.OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_b), .in_valid_i(vld),
    .pat_load_i(ld), .pat_in_i(pin),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in_i(5'b0),
`endif
    .cnt_clr_i(clr), .out_o(o1), .match_cnt_o(c1), .cnt_sat_o(s1));

  seq_det_prog #(.OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_b), .in_valid_i(vld),
    .pat_load_i(ld), .pat_in_i(pin),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in_i(5'b0),
`endif
    .cnt_clr_i(clr), .out_o(o2), .match_cnt_o(c2), .cnt_sat_o(s2));

  // Reference: the last received bits as a queue, oldest first.
  bit         q0[$], q1[$], q2[$];
  logic [4:0] mpat;
  bit         eo[3];
  int         ecnt[3];
  int         cmax[3] = '{255, 255, 3};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp,
               $time);
    end
  endtask

  function automatic bit q_match(input bit q[$], input logic [4:0] p);
    if (q.size() < 5) return 1'b0;
    for (int k = 0; k < 5; k++)
      if (q[q.size() - 5 + k] != p[4 - k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    mpat = 5'b10110;
    for (int m = 0; m < 3; m++) begin
      eo[m]   = 1'b0;
      ecnt[m] = 0;
    end
  endtask

  task automatic model_step();
    bit h[3];
    h = '{1'b0, 1'b0, 1'b0};
    if (ld) begin
      mpat = pin;
      q0.delete(); q1.delete(); q2.delete();
    end else if (vld) begin
      q0.push_back(in_b); if (q0.size() > 5) void'(q0.pop_front());
      q1.push_back(in_b); if (q1.size() > 5) void'(q1.pop_front());
      q2.push_back(in_b); if (q2.size() > 5) void'(q2.pop_front());
      h[0] = q_match(q0, mpat);
      h[1] = q_match(q1, mpat);
      h[2] = q_match(q2, mpat);
      if (h[1]) q1.delete();
    end
    for (int m = 0; m < 3; m++) begin
      eo[m] = h[m];
      if (clr)                         ecnt[m] = 0;
      else if (h[m] && ecnt[m] < cmax[m]) ecnt[m]++;
    end
  endtask

  task automatic check_all();
    chk("out0", 32'(o0), 32'(eo[0]));
    chk("out1", 32'(o1), 32'(eo[1]));
    chk("out2", 32'(o2), 32'(eo[2]));
    chk("cnt0", 32'(c0), 32'(ecnt[0]));
    chk("cnt1", 32'(c1), 32'(ecnt[1]));
    chk("cnt2", 32'(c2), 32'(ecnt[2]));
    chk("sat0", 32'(s0), 32'(ecnt[0] == cmax[0]));
    chk("sat1", 32'(s1), 32'(ecnt[1] == cmax[1]));
    chk("sat2", 32'(s2), 32'(ecnt[2] == cmax[2]));
  endtask

  task automatic cyc(input bit b, input bit v, input bit l,
                     input logic [4:0] p, input bit c);
    @(negedge clk);
    in_b = b; vld = v; ld = l; pin = p; clr = c;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic bit_in(input bit b);
    cyc(b, 1'b1, 1'b0, 5'b0, 1'b0);
  endtask

  task automatic idle(input bit c);
    cyc(1'b0, 1'b0, 1'b0, 5'b0, c);
  endtask

  // Reset lands between edges; its effect must be visible before any clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    vld = 1'b0; ld = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_out0"}, 32'(o0), 32'd0);
    chk({tag, "_cnt0"}, 32'(c0), 32'd0);
    chk({tag, "_cnt2"}, 32'(c2), 32'd0);
    chk({tag, "_sat2"}, 32'(s2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit v5[8];
    rst_n = 1'b0; in_b = 1'b0; vld = 1'b0; ld = 1'b0; clr = 1'b0;
    pin = 5'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    v5 = '{1, 0, 1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 8; i++) bit_in(v5[i]);
    chk("tp1_cnt_ovl", 32'(c0), 32'd2);
    chk("tp1_cnt_novl", 32'(c1), 32'd1);

    idle(1'b1);
    bit_in(1); bit_in(0); bit_in(1);
    repeat (3) idle(1'b0);
    bit_in(1); bit_in(0);
    chk("tp3_pulse", 32'(o0), 32'd1);
    chk("tp3_cnt", 32'(c0), 32'd1);

    bit_in(1); bit_in(1); bit_in(0);
    cyc(1'b1, 1'b1, 1'b1, 5'b11001, 1'b0);
    bit_in(1); bit_in(1); bit_in(0); bit_in(0); bit_in(1);
    chk("tp4_pulse", 32'(o0), 32'd1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0);

    cyc(1'b0, 1'b0, 1'b1, 5'b11111, 1'b1);
    for (int i = 0; i < 8; i++) bit_in(1);
    chk("tp5_cnt2", 32'(c2), 32'd3);
    chk("tp5_sat2", 32'(s2), 32'd1);
    idle(1'b1);
    chk("tp5_clr_cnt2", 32'(c2), 32'd0);
    chk("tp5_clr_sat2", 32'(s2), 32'd0);

    bit_in(1); bit_in(0); bit_in(1); bit_in(1);
    async_reset("tp6");
    bit_in(0);
    chk("tp6_nopulse", 32'(o0), 32'd0);
    bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0);
    chk("tp6_pulse", 32'(o0), 32'd1);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(299) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cyc(1'($urandom_range(1)),
            $urandom_range(99) < 80,
            $urandom_range(99) < 3,
            5'($urandom),
            $urandom_range(99) < 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
